// File: rtl/sfft_frame_reader_if.sv
// Bundle between the SFFT pipeline, the frame reader and its downstream bin consumer.
// The slave modport is the frame reader's view; master is the surrounding system's view.
interface sfft_frame_reader_if #(
    parameter int NFFT  = 32,
    parameter int WIDTH = 24
);
    localparam int IDXW = $clog2(NFFT);

    logic [WIDTH-1:0] SFFT_In [NFFT];
    logic             InputValid;
    logic [WIDTH-1:0] BinOut;
    logic [IDXW-1:0]  BinIndex;
    logic             BinValid;
    logic             BinReady;
    logic             FrameStart;
    logic             FrameEnd;
    logic             Busy;
    logic [7:0]       DroppedFrames;

    modport slave (
        input  SFFT_In, InputValid, BinReady,
        output BinOut, BinIndex, BinValid, FrameStart, FrameEnd, Busy, DroppedFrames
    );

    modport master (
        output SFFT_In, InputValid, BinReady,
        input  BinOut, BinIndex, BinValid, FrameStart, FrameEnd, Busy, DroppedFrames
    );
endinterface

// File: rtl/sfft_frame_reader.sv
// Captures one parallel SFFT frame on the rising edge of InputValid and streams its
// bins out one per valid/ready handshake; frames arriving mid-stream are dropped and counted.
module sfft_frame_reader #(
    parameter int NFFT  = 32,
    parameter int WIDTH = 24,
    parameter int IDXW  = $clog2(NFFT)
) (
    input  logic               clk,
    input  logic               reset_n,
    sfft_frame_reader_if.slave bus
);
    localparam logic [0:0]      IDLE     = 1'b0;
    localparam logic [0:0]      STREAM   = 1'b1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFFT - 1);

    logic [0:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             ivPrev_q;
    logic [7:0]       dropped_q, dropped_d;
    logic [WIDTH-1:0] buf_q [NFFT];

    logic newFrame;
    logic handshake;
    logic lastHs;
    logic capture;
    logic drop;

    // A frame landing on the final handshake is captured so back-to-back frames have no bubble.
    assign newFrame  = bus.InputValid & ~ivPrev_q;
    assign handshake = (state_q == STREAM) & bus.BinReady;
    assign lastHs    = handshake & (idx_q == LAST_IDX);
    assign capture   = newFrame & ((state_q == IDLE) | lastHs);
    assign drop      = newFrame & (state_q == STREAM) & ~lastHs;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dropped_d = dropped_q;
        if (capture) begin
            state_d = STREAM;
            idx_d   = '0;
        end else if (lastHs) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (handshake) begin
            idx_d = idx_q + IDXW'(1);
        end
        if (drop && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ivPrev_q  <= 1'b0;
            dropped_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ivPrev_q  <= bus.InputValid;
            dropped_q <= dropped_d;
        end
    end

    // The buffer needs no reset: BinOut is gated off outside STREAM.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NFFT; i++) begin
                buf_q[i] <= bus.SFFT_In[i];
            end
        end
    end

    assign bus.BinValid      = (state_q == STREAM);
    assign bus.Busy          = (state_q == STREAM);
    assign bus.BinIndex      = idx_q;
    assign bus.BinOut        = (state_q == STREAM) ? buf_q[idx_q] : '0;
    assign bus.FrameStart    = (state_q == STREAM) & (idx_q == '0);
    assign bus.FrameEnd      = (state_q == STREAM) & (idx_q == LAST_IDX);
    assign bus.DroppedFrames = dropped_q;
endmodule

// File: tb/tb_sfft_frame_reader.sv
// Scoreboard bench for sfft_frame_reader: the driver models frame acceptance from the
// handshake rules and queues expected bins; a negedge monitor pops and compares them.
module tb_sfft_frame_reader;
    localparam int NFFT  = 32;
    localparam int WIDTH = 24;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] val;
    } bin_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   fsCount = 0;

    bin_t expQ[$];
    int   pending = 0;
    bit   prevIV = 1'b0;
    int   dropModel = 0;

    sfft_frame_reader_if #(.NFFT(NFFT), .WIDTH(WIDTH)) bus ();

    sfft_frame_reader #(.NFFT(NFFT), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference model: a frame is accepted only when no bins remain outstanding after this edge.
    task automatic modelEdge();
        bit nf;
        bit hs;
        nf = bus.InputValid && !prevIV;
        hs = (pending > 0) && bus.BinReady;
        prevIV = bus.InputValid;
        if (hs) pending--;
        if (nf) begin
            if (pending == 0) begin
                for (int k = 0; k < NFFT; k++) begin
                    bin_t e;
                    e.idx = k;
                    e.val = bus.SFFT_In[k];
                    expQ.push_back(e);
                end
                pending = NFFT;
            end else if (dropModel < 255) begin
                dropModel++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) modelEdge();
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic rdy);
        bus.InputValid = iv;
        bus.BinReady   = rdy;
    endtask

    task automatic loadFrame(input int base, input int step);
        for (int k = 0; k < NFFT; k++) bus.SFFT_In[k] = WIDTH'(base + step * k);
    endtask

    task automatic loadRandom();
        for (int k = 0; k < NFFT; k++) bus.SFFT_In[k] = WIDTH'($urandom);
    endtask

    task automatic pulseReset();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rstBinValid", bus.BinValid, 0);
        checkOutput("rstBinOut", bus.BinOut, 0);
        checkOutput("rstBinIndex", bus.BinIndex, 0);
        checkOutput("rstFrameStart", bus.FrameStart, 0);
        checkOutput("rstFrameEnd", bus.FrameEnd, 0);
        checkOutput("rstBusy", bus.Busy, 0);
        checkOutput("rstDropped", bus.DroppedFrames, 0);
        expQ.delete();
        pending   = 0;
        prevIV    = 1'b0;
        dropModel = 0;
        bus.InputValid = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    task automatic waitIndex(input int target);
        int n = 0;
        while (!(bus.BinValid && (int'(bus.BinIndex) == target)) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) reportTimeout("waitIndex");
    endtask

    task automatic captureFrame(input int base, input int step);
        loadFrame(base, step);
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1);
    endtask

    task automatic drain(input int n);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frameLength(input bit alternate, input int expCycles, input string name);
        int cnt = 0;
        captureFrame(0, 3);
        while (bus.Busy && cnt < 200) begin
            tick();
            cnt++;
            if (alternate) bus.BinReady = ~bus.BinReady;
        end
        if (cnt >= 200) reportTimeout(name);
        else checkOutput(name, cnt, expCycles);
        drain(3);
    endtask

    // Monitor: every presented bin must match the queue head; it is retired only on handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("BinValid", bus.BinValid, (expQ.size() > 0));
            checkOutput("Busy", bus.Busy, (expQ.size() > 0));
            checkOutput("DroppedFrames", bus.DroppedFrames, dropModel);
            if (bus.BinValid && expQ.size() > 0) begin
                checkOutput("BinIndex", bus.BinIndex, expQ[0].idx);
                checkOutput("BinOut", bus.BinOut, expQ[0].val);
                checkOutput("FrameStart", bus.FrameStart, (expQ[0].idx == 0));
                checkOutput("FrameEnd", bus.FrameEnd, (expQ[0].idx == NFFT - 1));
                if (bus.BinReady) begin
                    if (bus.FrameStart) fsCount++;
                    void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0);
        loadFrame(0, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        $display("[TB] reset with random inputs");
        loadRandom();
        applyStimulus(1'($urandom), 1'($urandom));
        tick();
        tick();
        pulseReset();
        drain(4);

        $display("[TB] single frame, no backpressure");
        frameLength(1'b0, NFFT, "frameCycles");

        $display("[TB] single frame, alternating BinReady");
        frameLength(1'b1, 2 * NFFT - 1, "frameCyclesBp");

        $display("[TB] dropped frame");
        pulseReset();
        captureFrame(0, 3);
        waitIndex(10);
        loadFrame(1000, 1);
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1);
        tick();
        checkOutput("dropOne", bus.DroppedFrames, 1);
        drain(30);

        $display("[TB] level-held InputValid");
        pulseReset();
        fsCount = 0;
        loadFrame(0, 3);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 100; i++) tick();
        drain(5);
        checkOutput("levelFrames", fsCount, 1);
        checkOutput("levelDrops", bus.DroppedFrames, 0);

        $display("[TB] coincident edge on final bin");
        pulseReset();
        captureFrame(0, 3);
        waitIndex(NFFT - 1);
        loadFrame(500, 1);
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1);
        checkOutput("coinIndex", bus.BinIndex, 0);
        checkOutput("coinOut", bus.BinOut, 500);
        checkOutput("coinStart", bus.FrameStart, 1);
        checkOutput("coinDrops", bus.DroppedFrames, 0);
        drain(40);

        $display("[TB] drop counter saturation");
        pulseReset();
        captureFrame(0, 3);
        bus.BinReady = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.InputValid = 1'b1;
            tick();
            bus.InputValid = 1'b0;
            tick();
        end
        checkOutput("satDrops", bus.DroppedFrames, 255);
        drain(40);

        $display("[TB] reset mid-stream");
        pulseReset();
        captureFrame(0, 3);
        waitIndex(5);
        pulseReset();
        captureFrame(7, 2);
        checkOutput("freshIndex", bus.BinIndex, 0);
        checkOutput("freshOut", bus.BinOut, 7);
        drain(40);

        $display("[TB] randomized traffic");
        pulseReset();
        for (int i = 0; i < 3000; i++) begin
            loadRandom();
            applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
            tick();
        end
        drain(80);
        checkOutput("drained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
